// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the multiplexed seven-segment scan decoder:
// FSM encoding, segment bit positions and the hex glyph table.
package seg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2
    } scan_state_t;

    localparam int NUM_DIGITS = 4;
    localparam int GLYPH_W    = 7;
    localparam int SEG_G_BIT  = 6;
    localparam int SEG_DP_BIT = 7;

    // Active-high a..g patterns; element i is the glyph for hex value i.
    localparam logic [15:0][GLYPH_W-1:0] GLYPH_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [1:0] dig_index(input logic [3:0] sel_n);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!sel_n[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Combinational lookup of an active-high 7-segment pattern into its hex
// value; legal is low when the pattern is not one of the 16 hex glyphs.
module seg7_glyph_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [GLYPH_W-1:0] pattern,
    output logic [3:0]         value,
    output logic               legal
);

    // NOTE: every output gets a default before the search loop so that no
    // path through the block leaves a value held, which would infer a latch.
    always_comb begin
        value = 4'h0;
        legal = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern == GLYPH_TABLE[i]) begin
                value = 4'(i);
                legal = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Recovers four hex digits from the segment/digit-select lines of a
// multiplexed LED display, with settling, repeat confirmation and staleness.
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int CONFIRM_N   = 2,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg_n,
    input  logic [3:0]  dig_n,
    output logic [15:0] digit_val,
    output logic [3:0]  digit_dp,
    output logic [3:0]  digit_valid,
    output logic [3:0]  digit_bad,
    output logic        update
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int CW = $clog2(CONFIRM_N + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [7:0] seg_m, seg_s;
    logic [3:0] dig_m, dig_s;

    scan_state_t   state;
    logic [3:0]    dig_ref;
    logic [1:0]    dig_idx;
    logic [SW-1:0] settle_cnt;
    logic          armed;

    logic [7:0]    last_pat  [NUM_DIGITS];
    logic [CW-1:0] match_cnt [NUM_DIGITS];
    logic [7:0]    com_pat   [NUM_DIGITS];
    logic [TW-1:0] idle_cnt  [NUM_DIGITS];
    logic [3:0]    has_com;

    logic          capture;
    logic [CW-1:0] cap_cnt;
    logic          commit;
    logic [3:0]    timeout;
    logic [3:0]    glyph_val;
    logic          glyph_legal;
    logic [15:0]   nxt_val;
    logic [3:0]    nxt_dp, nxt_valid, nxt_bad;

    // NOTE: registers use non-blocking assignments so both synchronizer
    // stages sample the pre-edge values and the chain really is two flops deep.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_m <= '1;
            seg_s <= '1;
            dig_m <= '1;
            dig_s <= '1;
        end else begin
            seg_m <= seg_n;
            seg_s <= seg_m;
            dig_m <= dig_n;
            dig_s <= dig_m;
        end
    end

    // After a capture the same select must go away before it is sampled again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dig_ref    <= '1;
            dig_idx    <= '0;
            settle_cnt <= '0;
            armed      <= 1'b1;
        end else begin
            armed <= armed || (dig_s != dig_ref);
            case (state)
                ST_IDLE: begin
                    if ($onehot(~dig_s) && (armed || dig_s != dig_ref)) begin
                        state      <= ST_SETTLE;
                        dig_ref    <= dig_s;
                        dig_idx    <= dig_index(dig_s);
                        settle_cnt <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (dig_s != dig_ref) begin
                        state <= ST_IDLE;
                    end else if (settle_cnt == SW'(SETTLE_CYC - 1)) begin
                        state <= ST_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + SW'(1);
                    end
                end
                ST_CAPTURE: begin
                    state <= ST_IDLE;
                    armed <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    seg7_glyph_decode u_glyph (
        .pattern (~seg_s[GLYPH_W-1:0]),
        .value   (glyph_val),
        .legal   (glyph_legal)
    );

    always_comb begin
        capture = (state == ST_CAPTURE);
        cap_cnt = CW'(1);
        if (seg_s == last_pat[dig_idx]) begin
            if (match_cnt[dig_idx] == CW'(CONFIRM_N)) cap_cnt = match_cnt[dig_idx];
            else                                      cap_cnt = match_cnt[dig_idx] + CW'(1);
        end
        commit = capture && (cap_cnt == CW'(CONFIRM_N)) &&
                 (!has_com[dig_idx] || seg_s != com_pat[dig_idx]);

        nxt_val   = digit_val;
        nxt_dp    = digit_dp;
        nxt_valid = digit_valid;
        nxt_bad   = digit_bad;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            timeout[k] = !(capture && dig_idx == 2'(k)) &&
                         (idle_cnt[k] == TW'(TIMEOUT_CYC - 1));
            if (timeout[k]) nxt_valid[k] = 1'b0;
            // An illegal glyph keeps the last good value on the output.
            if (commit && dig_idx == 2'(k)) begin
                nxt_dp[k]    = ~seg_s[SEG_DP_BIT];
                nxt_bad[k]   = ~glyph_legal;
                nxt_valid[k] = glyph_legal;
                if (glyph_legal) nxt_val[4*k +: 4] = glyph_val;
            end
        end
    end

    // NOTE: the per-digit history arrays are reset explicitly; they are a
    // handful of flops, and a stale pattern surviving reset could suppress
    // the first commit after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            has_com <= '0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                last_pat[k]  <= '1;
                match_cnt[k] <= '0;
                com_pat[k]   <= '1;
                idle_cnt[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                if (capture && dig_idx == 2'(k)) begin
                    last_pat[k]  <= seg_s;
                    match_cnt[k] <= cap_cnt;
                    idle_cnt[k]  <= '0;
                    if (commit) begin
                        com_pat[k] <= seg_s;
                        has_com[k] <= 1'b1;
                    end
                end else begin
                    if (idle_cnt[k] != TW'(TIMEOUT_CYC)) idle_cnt[k] <= idle_cnt[k] + TW'(1);
                    // Forgetting the committed pattern lets a returning digit
                    // become valid again once it is reconfirmed.
                    if (timeout[k]) begin
                        match_cnt[k] <= '0;
                        has_com[k]   <= 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digit_val   <= '0;
            digit_dp    <= '0;
            digit_valid <= '0;
            digit_bad   <= '0;
            update      <= 1'b0;
        end else begin
            digit_val   <= nxt_val;
            digit_dp    <= nxt_dp;
            digit_valid <= nxt_valid;
            digit_bad   <= nxt_bad;
            update      <= {nxt_val, nxt_dp, nxt_valid, nxt_bad} !=
                           {digit_val, digit_dp, digit_valid, digit_bad};
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Scoreboard bench: each expected output snapshot is queued when the stimulus
// that should cause it is driven, and popped on every update pulse.
module tb_seg_scan_decoder;

    localparam int SETTLE_CYC  = 4;
    localparam int CONFIRM_N   = 2;
    localparam int TIMEOUT_CYC = 600;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg_n;
    logic [3:0]  dig_n;
    logic [15:0] digit_val;
    logic [3:0]  digit_dp, digit_valid, digit_bad;
    logic        update;

    typedef struct packed {
        logic [15:0] val;
        logic [3:0]  dp;
        logic [3:0]  valid;
        logic [3:0]  bad;
    } snap_t;

    snap_t sb[$];
    snap_t exp_s;
    snap_t mon_exp;
    int    tests_run    = 0;
    int    tests_failed = 0;
    int    pulse_cnt    = 0;

    seg_scan_decoder #(
        .SETTLE_CYC  (SETTLE_CYC),
        .CONFIRM_N   (CONFIRM_N),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg_n       (seg_n),
        .dig_n       (dig_n),
        .digit_val   (digit_val),
        .digit_dp    (digit_dp),
        .digit_valid (digit_valid),
        .digit_bad   (digit_bad),
        .update      (update)
    );

    always #5 clk = ~clk;

    function automatic snap_t observed();
        return {digit_val, digit_dp, digit_valid, digit_bad};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && update === 1'b1) begin
            pulse_cnt++;
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("FAIL unexpected_update: got %h, required no pulse", observed());
            end else begin
                mon_exp = sb.pop_front();
                if (observed() !== mon_exp) begin
                    tests_failed++;
                    $display("FAIL update_snapshot: got %h required %h", observed(), mon_exp);
                end
            end
        end
    end

    task automatic scan_digit(input int idx, input logic [7:0] seg);
        @(negedge clk);
        seg_n = seg;
        dig_n = ~(4'(1) << idx);
        repeat (12) @(negedge clk);
        dig_n = 4'hF;
        repeat (4) @(negedge clk);
    endtask

    task automatic set_digit(input int k, input logic [3:0] v, input logic dp,
                             input logic vld, input logic bad);
        exp_s.val[4*k +: 4] = v;
        exp_s.dp[k]         = dp;
        exp_s.valid[k]      = vld;
        exp_s.bad[k]        = bad;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        seg_n = 8'hFF;
        dig_n = 4'hF;
        exp_s = '0;
        repeat (3) @(negedge clk);
        tests_run++;
        if (observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required %h", observed(), exp_s);
        end
        tests_run++;
        if (update !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_update: got %b required 0", update);
        end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_single_digit();
        int p0;
        p0 = pulse_cnt;
        set_digit(0, 4'h9, 1'b0, 1'b1, 1'b0);
        sb.push_back(exp_s);
        for (int r = 0; r < 3; r++) scan_digit(0, 8'h90);
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL single_pulses: got %0d required 1", pulse_cnt - p0);
        end
        tests_run++;
        if (observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL single_outputs: got %h required %h", observed(), exp_s);
        end
    endtask

    task automatic test_scan4();
        logic [7:0] pats [4];
        logic [3:0] vals [4];
        int p0;
        pats = '{8'hC0, 8'hF9, 8'h92, 8'h8E};
        vals = '{4'h0, 4'h1, 4'h5, 4'hF};
        p0 = pulse_cnt;
        for (int k = 0; k < 4; k++) begin
            set_digit(k, vals[k], 1'b0, 1'b1, 1'b0);
            sb.push_back(exp_s);
        end
        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 4; k++) scan_digit(k, pats[k]);
        repeat (20) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL scan4_pending: got %0d left required 0", sb.size());
        end
        tests_run++;
        if (digit_val !== 16'hF510 || digit_valid !== 4'hF) begin
            tests_failed++;
            $display("FAIL scan4_outputs: got val=%h valid=%b required val=F510 valid=1111",
                     digit_val, digit_valid);
        end
        tests_run++;
        if (pulse_cnt - p0 !== 4) begin
            tests_failed++;
            $display("FAIL scan4_pulses: got %0d required 4", pulse_cnt - p0);
        end
    endtask

    task automatic test_blank();
        exp_s.valid[2] = 1'b0;
        exp_s.bad[2]   = 1'b1;
        exp_s.dp[2]    = 1'b0;
        sb.push_back(exp_s);
        scan_digit(2, 8'hFF);
        scan_digit(2, 8'hFF);
        repeat (20) @(negedge clk);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("FAIL blank_pending: got %0d left required 0", sb.size());
        end
        tests_run++;
        if (observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL blank_outputs: got %h required %h", observed(), exp_s);
        end
    endtask

    task automatic test_glitch();
        int p0;
        p0 = pulse_cnt;
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            seg_n = 8'hA4;
            dig_n = 4'b1101;
            repeat (3) @(negedge clk);
            dig_n = 4'b1100;
            repeat (4) @(negedge clk);
            dig_n = 4'hF;
            repeat (6) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt != p0 || observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL glitch_ignored: got %h pulses=%0d required %h pulses=0",
                     observed(), pulse_cnt - p0, exp_s);
        end
    endtask

    task automatic test_hold_no_rescan();
        int p0;
        p0 = pulse_cnt;
        @(negedge clk);
        seg_n = 8'h00;
        dig_n = 4'b0111;
        repeat (60) @(negedge clk);
        dig_n = 4'hF;
        repeat (4) @(negedge clk);
        tests_run++;
        if (pulse_cnt != p0) begin
            tests_failed++;
            $display("FAIL hold_single_capture: got %0d pulses required 0", pulse_cnt - p0);
        end
        set_digit(3, 4'h8, 1'b1, 1'b1, 1'b0);
        sb.push_back(exp_s);
        scan_digit(3, 8'h00);
        repeat (20) @(negedge clk);
        tests_run++;
        if (observed() !== exp_s || sb.size() != 0) begin
            tests_failed++;
            $display("FAIL hold_then_commit: got %h pending=%0d required %h pending=0",
                     observed(), sb.size(), exp_s);
        end
    endtask

    task automatic test_timeout();
        int p0;
        p0 = pulse_cnt;
        exp_s.valid[1] = 1'b0;
        sb.push_back(exp_s);
        for (int r = 0; r < 15; r++) begin
            scan_digit(0, 8'hC0);
            scan_digit(2, 8'hFF);
            scan_digit(3, 8'h00);
        end
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL timeout_pulses: got %0d required 1", pulse_cnt - p0);
        end
        tests_run++;
        if (observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL timeout_outputs: got %h required %h", observed(), exp_s);
        end
    endtask

    task automatic test_single_outlier();
        int p0;
        p0 = pulse_cnt;
        set_digit(1, 4'h8, 1'b0, 1'b1, 1'b0);
        sb.push_back(exp_s);
        scan_digit(1, 8'h80);
        scan_digit(1, 8'h80);
        scan_digit(1, 8'h90);
        scan_digit(1, 8'h80);
        scan_digit(1, 8'h80);
        repeat (20) @(negedge clk);
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL outlier_pulses: got %0d required 1", pulse_cnt - p0);
        end
        tests_run++;
        if (digit_val[7:4] !== 4'h8 || observed() !== exp_s) begin
            tests_failed++;
            $display("FAIL outlier_outputs: got %h required %h", observed(), exp_s);
        end
    endtask

    task automatic test_reset_mid_capture();
        int p0;
        scan_digit(0, 8'hF9);
        @(negedge clk);
        seg_n = 8'hF9;
        dig_n = 4'b1110;
        repeat (7) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        exp_s = '0;
        sb.delete();
        #1;
        tests_run++;
        if (observed() !== exp_s || update !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_capture: got %h upd=%b required %h upd=0",
                     observed(), update, exp_s);
        end
        repeat (3) @(negedge clk);
        dig_n = 4'hF;
        rst_n = 1'b1;
        p0 = pulse_cnt;
        repeat (30) @(negedge clk);
        tests_run++;
        if (observed() !== exp_s || pulse_cnt != p0) begin
            tests_failed++;
            $display("FAIL reset_discards_capture: got %h pulses=%0d required %h pulses=0",
                     observed(), pulse_cnt - p0, exp_s);
        end
    endtask

    initial begin
        test_reset();
        test_single_digit();
        test_scan4();
        test_blank();
        test_glitch();
        test_hold_no_rescan();
        test_timeout();
        test_single_outlier();
        test_reset_mid_capture();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
